// File: rtl/axi_slice_dc_gate_ctrl.sv
// Clock-gate sequencer for the master-side dual-clock AXI slice: tracks outstanding
// traffic, drains it, isolates and gates the slice clock, and brings it back up.
module axi_slice_dc_gate_ctrl #(
  parameter int CNT_WIDTH     = 6,
  parameter int ISO_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int WAKE_ON_REQ   = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic gate_req_i,
  output logic gate_ack_o,
  input  logic incoming_req_i,
  input  logic aw_hs_i,
  input  logic w_last_hs_i,
  input  logic b_hs_i,
  input  logic ar_hs_i,
  input  logic r_last_hs_i,
  output logic clock_down_o,
  output logic isolate_o,
  output logic clk_en_o,
  output logic wake_o,
  output logic busy_o,
  output logic err_o
);

  localparam int TMR_W = 8;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_PREP,
    ST_DRAIN,
    ST_ISO,
    ST_GATED,
    ST_UNGATE
  } state_t;

  state_t state, state_d;

  logic [CNT_WIDTH-1:0]    wr_out, wr_out_d;
  logic [CNT_WIDTH-1:0]    rd_out, rd_out_d;
  logic signed [CNT_WIDTH:0] w_bal, w_bal_d;
  logic [TMR_W-1:0]        tmr, tmr_d;
  logic                    err_d, busy_d;
  logic                    clock_down_d, isolate_d, clk_en_d, gate_ack_d, wake_d;
  logic                    wake_req;

  // Outstanding counters; a counter that would wrap holds and flags a sticky error.
  always_comb begin
    wr_out_d = wr_out;
    rd_out_d = rd_out;
    err_d    = err_o;
    if (aw_hs_i && !b_hs_i) begin
      if (wr_out == CNT_MAX) err_d = 1'b1;
      else                   wr_out_d = wr_out + 1'b1;
    end else if (b_hs_i && !aw_hs_i) begin
      if (wr_out == '0) err_d = 1'b1;
      else              wr_out_d = wr_out - 1'b1;
    end
    if (ar_hs_i && !r_last_hs_i) begin
      if (rd_out == CNT_MAX) err_d = 1'b1;
      else                   rd_out_d = rd_out + 1'b1;
    end else if (r_last_hs_i && !ar_hs_i) begin
      if (rd_out == '0) err_d = 1'b1;
      else              rd_out_d = rd_out - 1'b1;
    end
    w_bal_d = w_bal + (CNT_WIDTH+1)'(aw_hs_i) - (CNT_WIDTH+1)'(w_last_hs_i);
    busy_d  = (wr_out_d != '0) || (rd_out_d != '0) || (w_bal_d != '0);
  end

  assign wake_req = (WAKE_ON_REQ != 0) && incoming_req_i;

  // Sequencer next state; every control output is produced as a registered next value.
  always_comb begin
    state_d      = state;
    tmr_d        = tmr;
    clock_down_d = clock_down_o;
    isolate_d    = isolate_o;
    clk_en_d     = clk_en_o;
    gate_ack_d   = gate_ack_o;
    wake_d       = 1'b0;
    case (state)
      ST_RUN: begin
        if (gate_req_i) state_d = ST_PREP;
      end
      ST_PREP: begin
        if (!gate_req_i) begin
          state_d = ST_RUN;
        end else if (w_bal_d == '0) begin
          clock_down_d = 1'b1;
          state_d      = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!gate_req_i) begin
          clock_down_d = 1'b0;
          state_d      = ST_RUN;
        end else if ((wr_out == '0) && (rd_out == '0)) begin
          isolate_d = 1'b1;
          tmr_d     = '0;
          state_d   = ST_ISO;
        end
      end
      ST_ISO: begin
        if (tmr == TMR_W'(ISO_CYCLES - 1)) begin
          clk_en_d   = 1'b0;
          gate_ack_d = 1'b1;
          state_d    = ST_GATED;
        end else begin
          tmr_d = tmr + 1'b1;
        end
      end
      ST_GATED: begin
        if (!gate_req_i || wake_req) begin
          clk_en_d   = 1'b1;
          gate_ack_d = 1'b0;
          wake_d     = gate_req_i;
          tmr_d      = '0;
          state_d    = ST_UNGATE;
        end
      end
      ST_UNGATE: begin
        // Isolation drops after the settle window, clock_down one cycle after that.
        if (tmr == TMR_W'(SETTLE_CYCLES)) begin
          clock_down_d = 1'b0;
          state_d      = ST_RUN;
        end else begin
          if (tmr == TMR_W'(SETTLE_CYCLES - 1)) isolate_d = 1'b0;
          tmr_d = tmr + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_RUN;
      tmr          <= '0;
      wr_out       <= '0;
      rd_out       <= '0;
      w_bal        <= '0;
      err_o        <= 1'b0;
      busy_o       <= 1'b0;
      clock_down_o <= 1'b0;
      isolate_o    <= 1'b0;
      clk_en_o     <= 1'b1;
      gate_ack_o   <= 1'b0;
      wake_o       <= 1'b0;
    end else begin
      state        <= state_d;
      tmr          <= tmr_d;
      wr_out       <= wr_out_d;
      rd_out       <= rd_out_d;
      w_bal        <= w_bal_d;
      err_o        <= err_d;
      busy_o       <= busy_d;
      clock_down_o <= clock_down_d;
      isolate_o    <= isolate_d;
      clk_en_o     <= clk_en_d;
      gate_ack_o   <= gate_ack_d;
      wake_o       <= wake_d;
    end
  end

endmodule

// File: tb/tb_axi_slice_dc_gate_ctrl.sv
// Bench for axi_slice_dc_gate_ctrl: directed gating sequences plus randomized traffic
// against an integer model of the outstanding-transaction bookkeeping.
module tb_axi_slice_dc_gate_ctrl;

  localparam int ISO_CYCLES    = 2;
  localparam int SETTLE_CYCLES = 4;
  localparam int CNT_MAX       = 63;

  logic clk_i, rst_i;
  logic gate_req_i, incoming_req_i;
  logic aw_hs_i, w_last_hs_i, b_hs_i, ar_hs_i, r_last_hs_i;
  logic gate_ack_o, clock_down_o, isolate_o, clk_en_o, wake_o, busy_o, err_o;

  int passes = 0;
  int total  = 0;
  int mWr = 0, mRd = 0, mWb = 0;
  logic mErr = 1'b0;

  axi_slice_dc_gate_ctrl #(
    .CNT_WIDTH(6), .ISO_CYCLES(ISO_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES), .WAKE_ON_REQ(1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .gate_req_i(gate_req_i), .gate_ack_o(gate_ack_o),
    .incoming_req_i(incoming_req_i),
    .aw_hs_i(aw_hs_i), .w_last_hs_i(w_last_hs_i), .b_hs_i(b_hs_i),
    .ar_hs_i(ar_hs_i), .r_last_hs_i(r_last_hs_i),
    .clock_down_o(clock_down_o), .isolate_o(isolate_o), .clk_en_o(clk_en_o),
    .wake_o(wake_o), .busy_o(busy_o), .err_o(err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checkOutput(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic applyStimulus(input logic gr, input logic inc, input logic aw, input logic wl,
                               input logic b, input logic ar, input logic rl);
    gate_req_i     = gr;
    incoming_req_i = inc;
    aw_hs_i        = aw;
    w_last_hs_i    = wl;
    b_hs_i         = b;
    ar_hs_i        = ar;
    r_last_hs_i    = rl;
  endtask

  // Reference bookkeeping: plain integers, saturating with a sticky error flag.
  task automatic modelUpdate();
    if (aw_hs_i && !b_hs_i) begin
      if (mWr == CNT_MAX) mErr = 1'b1; else mWr++;
    end else if (b_hs_i && !aw_hs_i) begin
      if (mWr == 0) mErr = 1'b1; else mWr--;
    end
    if (ar_hs_i && !r_last_hs_i) begin
      if (mRd == CNT_MAX) mErr = 1'b1; else mRd++;
    end else if (r_last_hs_i && !ar_hs_i) begin
      if (mRd == 0) mErr = 1'b1; else mRd--;
    end
    mWb = mWb + int'(aw_hs_i) - int'(w_last_hs_i);
  endtask

  task automatic modelReset();
    mWr = 0; mRd = 0; mWb = 0; mErr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    modelUpdate();
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_wr"}, 32'(dut.wr_out), 32'(mWr));
    checkOutput({tag, "_rd"}, 32'(dut.rd_out), 32'(mRd));
    checkOutput({tag, "_wbal"}, 32'($signed(dut.w_bal)), 32'(mWb));
    checkBit({tag, "_busy"}, busy_o, (mWr != 0) || (mRd != 0) || (mWb != 0));
    checkBit({tag, "_err"}, err_o, mErr);
  endtask

  // Release/wake path: clock back at once, isolation after the settle window, then clock_down.
  task automatic ungateCheck(input string tag, input logic wakeExp);
    tick();
    checkBit({tag, "_ug_clken"}, clk_en_o, 1'b1);
    checkBit({tag, "_ug_ack"}, gate_ack_o, 1'b0);
    checkBit({tag, "_ug_iso"}, isolate_o, 1'b1);
    checkBit({tag, "_ug_wake"}, wake_o, wakeExp);
    incoming_req_i = 1'b0;
    for (int i = 0; i < SETTLE_CYCLES - 1; i++) begin
      tick();
      checkBit({tag, "_settle_iso"}, isolate_o, 1'b1);
      checkBit({tag, "_settle_wake"}, wake_o, 1'b0);
    end
    tick();
    checkBit({tag, "_iso_off"}, isolate_o, 1'b0);
    checkBit({tag, "_cd_hold"}, clock_down_o, 1'b1);
    tick();
    checkBit({tag, "_cd_off"}, clock_down_o, 1'b0);
  endtask

  task automatic waitGated(input string tag);
    int n = 0;
    while (gate_ack_o !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checkBit({tag, "_gated"}, gate_ack_o, 1'b1);
    checkBit({tag, "_gated_clken"}, clk_en_o, 1'b0);
  endtask

  initial begin
    int n;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    modelReset();

    checkBit("rst_clken", clk_en_o, 1'b1);
    checkBit("rst_cd", clock_down_o, 1'b0);
    checkBit("rst_iso", isolate_o, 1'b0);
    checkBit("rst_ack", gate_ack_o, 1'b0);
    checkBit("rst_wake", wake_o, 1'b0);
    checkCounters("rst");
    tick();

    $display("[TB] idle gating");
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick();
    checkBit("idle_cd_c1", clock_down_o, 1'b0);
    tick();
    checkBit("idle_cd_c2", clock_down_o, 1'b1);
    checkBit("idle_iso_c2", isolate_o, 1'b0);
    tick();
    checkBit("idle_iso_c3", isolate_o, 1'b1);
    for (int i = 0; i < ISO_CYCLES - 1; i++) begin
      tick();
      checkBit("idle_clken_iso", clk_en_o, 1'b1);
      checkBit("idle_ack_iso", gate_ack_o, 1'b0);
    end
    tick();
    checkBit("idle_clken_off", clk_en_o, 1'b0);
    checkBit("idle_ack_on", gate_ack_o, 1'b1);
    repeat (3) tick();
    checkBit("idle_ack_hold", gate_ack_o, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    ungateCheck("idle", 1'b0);

    $display("[TB] drain");
    applyStimulus(0, 0, 1, 0, 0, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    tick();
    checkCounters("drain_pre");
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick();
    checkBit("drain_cd_beat1", clock_down_o, 1'b0);
    tick();
    checkBit("drain_cd_beat2", clock_down_o, 1'b0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    tick();
    checkBit("drain_cd_beat3", clock_down_o, 1'b1);
    checkCounters("drain_wlast");
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    checkBit("drain_ack_wait", gate_ack_o, 1'b0);
    checkBit("drain_iso_wait", isolate_o, 1'b0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    tick();
    checkBit("drain_iso_b", isolate_o, 1'b0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    tick();
    checkBit("drain_iso_r1", isolate_o, 1'b0);
    tick();
    checkBit("drain_iso_r2", isolate_o, 1'b0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick();
    checkBit("drain_iso_on", isolate_o, 1'b1);
    checkBit("drain_ack_iso", gate_ack_o, 1'b0);
    repeat (ISO_CYCLES) tick();
    checkBit("drain_ack_on", gate_ack_o, 1'b1);
    checkCounters("drain_gated");
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    ungateCheck("drain", 1'b0);

    $display("[TB] abort");
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkBit("abort_cd_on", clock_down_o, 1'b1);
    tick();
    checkBit("abort_cd_drain", clock_down_o, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    checkBit("abort_cd_off", clock_down_o, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkBit("abort_iso_never", isolate_o, 1'b0);
      checkBit("abort_cd_stays", clock_down_o, 1'b0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    tick();
    checkCounters("abort_done");

    $display("[TB] W before AW");
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    tick();
    checkCounters("wfirst_neg");
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    tick();
    checkCounters("wfirst_aw");
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    tick();
    checkCounters("wfirst_b");

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)),
                    (mWr < 60) ? 1'($urandom_range(0, 1)) : 1'b0,
                    (mWb > 0) ? 1'($urandom_range(0, 1)) : 1'b0,
                    (mWr > 0) ? 1'($urandom_range(0, 1)) : 1'b0,
                    (mRd < 60) ? 1'($urandom_range(0, 1)) : 1'b0,
                    (mRd > 0) ? 1'($urandom_range(0, 1)) : 1'b0);
      tick();
      checkCounters("rand");
      checkBit("rand_wake", wake_o, 1'b0);
      checkBit("rand_clken", clk_en_o, 1'b1);
    end
    n = 0;
    while ((mWr != 0 || mRd != 0 || mWb != 0) && n < 200) begin
      applyStimulus(0, 0, 0, mWb > 0, mWr > 0, 0, mRd > 0);
      tick();
      n++;
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    checkCounters("rand_cleared");

    $display("[TB] autonomous wake");
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    waitGated("wake_pre");
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    ungateCheck("wake", 1'b1);
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    tick();
    checkBit("rewake_cd_prep", clock_down_o, 1'b0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick();
    checkBit("rewake_cd_on", clock_down_o, 1'b1);
    tick();
    checkBit("rewake_iso_wait", isolate_o, 1'b0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    tick();
    checkBit("rewake_iso_r", isolate_o, 1'b0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick();
    checkBit("rewake_iso_on", isolate_o, 1'b1);
    waitGated("rewake");
    checkBit("rewake_wake_low", wake_o, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    ungateCheck("rewake", 1'b0);

    $display("[TB] counter integrity");
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    repeat (63) tick();
    checkCounters("cnt_63");
    tick();
    checkCounters("cnt_ovf");
    checkOutput("cnt_ovf_rd", 32'(dut.rd_out), 32'd63);
    checkBit("cnt_ovf_err", err_o, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    tick();
    checkOutput("cnt_simul_rd", 32'(dut.rd_out), 32'd63);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    repeat (63) tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    checkCounters("cnt_drained");

    $display("[TB] reset mid-ISO");
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    checkBit("riso_iso_on", isolate_o, 1'b1);
    rst_i = 1'b1;
    #1;
    modelReset();
    checkBit("riso_clken", clk_en_o, 1'b1);
    checkBit("riso_iso", isolate_o, 1'b0);
    checkBit("riso_cd", clock_down_o, 1'b0);
    checkBit("riso_ack", gate_ack_o, 1'b0);
    checkCounters("riso");
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    tick();
    checkBit("post_rst_clken", clk_en_o, 1'b1);
    checkCounters("post_rst");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
